wb_ram_responder: RTL and testbench
===================================

Name: wb_ram_responder

Overview:
- Wishbone-style single-port word-addressed RAM responder; the memory-side endpoint for the CPU memory controller.
- Accepts single-beat strobed reads and writes with 4-bit byte-lane selects.
- Inserts a configurable number of wait states, holding stall while busy, then returns a one-cycle ack with read data.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words implemented.
- ADDR_W, 10, index width; must equal clog2(DEPTH_WORDS).
- WAIT_STATES, 1, extra cycles between acceptance and completion; legal range 0..15.

Ports:
- i_clk  input  1  single clock; all state changes on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_wb_stb  input  1  request strobe; sampled only while o_wb_stall=0.
- i_wb_we  input  1  1=write, 0=read.
- i_wb_addr  input  32  word address (byte address >> 2).
- i_wb_data  input  32  write data, lane-aligned.
- i_wb_sel  input  4  byte-lane enables; bit n covers data[8n+7:8n].
- o_wb_ack  output  1  one-cycle completion pulse.
- o_wb_stall  output  1  high while a request is in progress.
- o_wb_data  output  32  read data, valid with o_wb_ack for reads.

Behaviour:
- Reset values:
  - o_wb_ack=0, o_wb_stall=0, o_wb_data=0, state=S_IDLE, wait counter=0.
  - RAM contents are not cleared by reset.
- States:
  - S_IDLE:
    - Clears o_wb_ack.
    - If i_wb_stb && !o_wb_stall: capture addr, data, sel and we; set o_wb_stall<=1; load counter<=WAIT_STATES; go to S_WAIT.
  - S_WAIT:
    - If counter!=0: decrement counter.
    - Else perform the access, set o_wb_ack<=1 and o_wb_stall<=0, return to S_IDLE.
- Latency:
  - Strobe sampled at edge E0; ack is high during the cycle after edge E(1+WAIT_STATES).
  - Example: WAIT_STATES=1 gives ack visible 2 cycles after the accepting edge.
  - Ack lasts exactly one cycle.
- Back-to-back requests:
  - The ack cycle has stall=0, so a strobe present in the ack cycle is accepted at the following edge.
  - In that case ack falls and stall rises on the same edge.
- Strobes arriving while o_wb_stall=1 are ignored. They are not queued and produce no ack.
- Write:
  - For each n with sel[n]=1, mem[idx][8n+7:8n] <= data[8n+7:8n].
  - Lanes with sel[n]=0 are unchanged.
  - sel=4'b0000 writes nothing but still acks.
  - o_wb_data is unchanged by writes.
- Read:
  - o_wb_data <= mem[idx] (full word, sel ignored), registered on the completing edge.
  - o_wb_data holds its value until the next read completes.
- Addressing:
  - idx = captured addr[ADDR_W-1:0] when addr < DEPTH_WORDS.
  - Out-of-range addresses do not wrap:
    - reads return 32'hFFFFFFFF;
    - writes are dropped;
    - ack is still generated with normal latency.
- Captured request fields are frozen for the whole transaction. Input changes after acceptance have no effect.
- Reset mid-transaction:
  - Aborts the transaction immediately.
  - A write not yet at its completing edge is not committed.
  - No ack is issued; stall=0 on the next cycle.
- Reset and strobe asserted together: reset wins and the request is not accepted.
- Read of a never-written location returns the simulator's initial contents. The bench must not depend on this value.

Test Plan:
- Full-word write, then read (WAIT_STATES=1):
  - Write addr=5, data=32'hDEADBEEF, sel=4'b1111.
  - Then read addr=5.
  - Each ack appears exactly 2 cycles after acceptance; read returns 32'hDEADBEEF.
- Byte-lane write:
  - Preload addr=7 with 32'h11223344.
  - Write data=32'hAABBCCDD, sel=4'b0100.
  - Read addr=7 returns 32'h11BB3344.
  - Repeat with sel=4'b0000: data stays 32'h11BB3344 and ack is still seen.
- Stall discipline:
  - Assert i_wb_stb continuously for 10 cycles with alternating addresses.
  - Exactly one ack per accepted request, acceptances only when stall=0, no duplicated or lost writes.
  - With WAIT_STATES=1, expect 3 acks in 10 cycles.
- Out-of-range (DEPTH_WORDS=1024):
  - Write 32'h12345678 to addr=1024, then read addr=1024 and addr=0.
  - Addr=1024 reads 32'hFFFFFFFF.
  - Addr=0 keeps its previously written value 32'hCAFEF00D.
- Reset mid-write:
  - Write 32'h55555555 to addr=3 (previously 32'h0), with WAIT_STATES=3.
  - Assert i_reset at cycle 2 after acceptance.
  - No ack; stall=0 after reset; a subsequent read of addr=3 returns 32'h0.
- Latency sweep WAIT_STATES=0 and 4:
  - Ack is 1 and 5 cycles after the accepting edge respectively.
  - o_wb_data keeps the last read value through intervening writes.

Source files
------------

// File: rtl/wb_ram_responder.sv
// -----------------------------------------------------------------------------
// wb_ram_responder
//
// Single-port, word-addressed RAM that acts as the memory-side endpoint of a
// Wishbone-style bus. One single-beat request (read or write, with byte-lane
// selects) is accepted at a time. After acceptance the responder stays stalled
// for WAIT_STATES extra cycles, then performs the access and pulses ack for
// one cycle. Read data is registered on the completing edge and held until the
// next read completes.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words implemented
//   ADDR_W      : index width, equal to clog2(DEPTH_WORDS)
//   WAIT_STATES : extra cycles between acceptance and completion (0..15)
//
// Ports
//   i_clk      : clock, all state changes on the rising edge
//   i_reset    : synchronous active-high reset
//   i_wb_stb   : request strobe, only sampled while o_wb_stall is low
//   i_wb_we    : 1 = write, 0 = read
//   i_wb_addr  : word address (byte address >> 2)
//   i_wb_data  : lane-aligned write data
//   i_wb_sel   : byte-lane enables, bit n covers data[8n+7:8n]
//   o_wb_ack   : one-cycle completion pulse
//   o_wb_stall : high while a request is in progress
//   o_wb_data  : read data, valid with o_wb_ack for reads
// -----------------------------------------------------------------------------
module wb_ram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  count;
    logic [3:0]  count_nxt;
    logic        ack_nxt;
    logic        stall_nxt;
    logic        accept;
    logic        complete;

    // Request fields frozen at acceptance; bus inputs are ignored afterwards.
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic              in_range;
    logic [ADDR_W-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    // The full 32-bit address is range-checked so that out-of-range requests
    // never alias onto a valid word.
    assign in_range = (addr_q < DEPTH_LIM);
    assign idx      = addr_q[ADDR_W-1:0];

    // Returns the read value for the captured address: out-of-range reads
    // answer all ones.
    function automatic logic [31:0] read_value(input logic        ok,
                                               input logic [31:0] word);
        return ok ? word : 32'hFFFF_FFFF;
    endfunction

    // ---------------- next-state / output decode ----------------
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ack_nxt   = 1'b0;
        stall_nxt = o_wb_stall;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_wb_stb && !o_wb_stall) begin
                    accept    = 1'b1;
                    stall_nxt = 1'b1;
                    count_nxt = WAIT_INIT;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (count != 4'd0) begin
                    count_nxt = count - 4'd1;
                end else begin
                    complete  = 1'b1;
                    ack_nxt   = 1'b1;
                    stall_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            count      <= 4'd0;
            o_wb_ack   <= 1'b0;
            o_wb_stall <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            o_wb_ack   <= ack_nxt;
            o_wb_stall <= stall_nxt;
        end
    end

    // ---------------- request capture ----------------
    // No reset: a reset returns the FSM to idle, so stale fields are never used.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_q <= i_wb_addr;
            data_q <= i_wb_data;
            sel_q  <= i_wb_sel;
            we_q   <= i_wb_we;
        end
    end

    // ---------------- memory write ----------------
    // Gated by reset so that an aborted write is never committed.
    always_ff @(posedge i_clk) begin
        if (!i_reset && complete && we_q && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    mem[idx][8*n +: 8] <= data_q[8*n +: 8];
                end
            end
        end
    end

    // ---------------- read data ----------------
    // Updated only by completing reads; writes leave the last read value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_data <= 32'd0;
        end else if (complete && !we_q) begin
            o_wb_data <= read_value(in_range, mem[idx]);
        end
    end

endmodule

// File: tb/tb_wb_ram_responder.sv
module tb_wb_ram_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [1:0]  cur;
    logic [3:0]  stbv;
    logic [3:0]  ack;
    logic [3:0]  stall;
    logic [31:0] rdat [4];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [4][16];
    logic [31:0] exp_q [$];

    // Only the currently selected instance sees the strobe.
    assign stbv = {4{stb}} & (4'b0001 << cur);

    // Instance 0: WAIT_STATES=1, 1: 3, 2: 0, 3: 4
    wb_ram_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
        .i_clk(clk), .i_reset(rst), .i_wb_stb(stbv[0]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack[0]), .o_wb_stall(stall[0]),
        .o_wb_data(rdat[0]));
    wb_ram_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
        .i_clk(clk), .i_reset(rst), .i_wb_stb(stbv[1]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack[1]), .o_wb_stall(stall[1]),
        .o_wb_data(rdat[1]));
    wb_ram_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
        .i_clk(clk), .i_reset(rst), .i_wb_stb(stbv[2]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack[2]), .o_wb_stall(stall[2]),
        .o_wb_data(rdat[2]));
    wb_ram_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(4)) u_ws4 (
        .i_clk(clk), .i_reset(rst), .i_wb_stb(stbv[3]), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack[3]), .o_wb_stall(stall[3]),
        .o_wb_data(rdat[3]));

    function automatic logic [31:0] model_read(input logic [1:0] d, input logic [31:0] a);
        if (a >= 32'd1024) return 32'hFFFF_FFFF;
        return model[d][a[3:0]];
    endfunction

    function automatic void model_write(input logic [1:0] d, input logic [31:0] a,
                                        input logic [31:0] dat, input logic [3:0] s);
        if (a < 32'd1024) begin
            for (int n = 0; n < 4; n++) begin
                if (s[n]) model[d][a[3:0]][8*n +: 8] = dat[8*n +: 8];
            end
        end
    endfunction

    // Drives one request on the selected instance; returns edges from the
    // accepting edge to ack (-1 if none) and the read data seen with ack.
    // Expected read data is pushed to the scoreboard when the request is driven.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [31:0] rd);
        for (int i = 0; i < 50 && stall[cur]; i++) begin
            @(posedge clk); #1;
        end
        stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        if (!w) exp_q.push_back(model_read(cur, a));
        @(posedge clk); #1;
        if (w) model_write(cur, a, d, s);
        stb = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; sel = 4'($urandom);
        lat = -1;
        rd  = 'x;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (ack[cur]) begin
                lat = i;
                rd  = rdat[cur];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'd9; wdata = 32'h1; sel = 4'hF; cur = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (ack[d] !== 1'b0 || stall[d] !== 1'b0 || rdat[d] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: ack=%b stall=%b data=%h, required 0/0/00000000",
                         d, ack[d], stall[d], rdat[d]);
            end
        end
        rst = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (stall[0] !== 1'b0 || ack[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_with_stb: stall=%b ack=%b, required 0/0", stall[0], ack[0]);
        end
    endtask

    task automatic test_full_word();
        int lat; logic [31:0] rd, exp;
        cur = 2'd0;
        do_req(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, lat, rd);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL fw_write_lat: got %0d required 2", lat); end
        @(posedge clk); #1;
        n_cmp++;
        if (ack[0] !== 1'b0) begin n_err++; $display("FAIL ack_one_cycle: ack=%b required 0", ack[0]); end
        do_req(1'b0, 32'd5, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL fw_read_lat: got %0d required 2", lat); end
        n_cmp++;
        if (rd !== exp || rd !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL fw_read_data: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_byte_lane();
        int lat; logic [31:0] rd, exp;
        cur = 2'd0;
        do_req(1'b1, 32'd7, 32'h11223344, 4'hF, lat, rd);
        do_req(1'b1, 32'd7, 32'hAABBCCDD, 4'b0100, lat, rd);
        do_req(1'b0, 32'd7, 32'h0, 4'h0, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'h11BB3344) begin
            n_err++; $display("FAIL lane_sel0100: got %h required %h", rd, exp);
        end
        do_req(1'b1, 32'd7, 32'h99887766, 4'b0000, lat, rd);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL sel0_ack: latency %0d required 2", lat); end
        do_req(1'b0, 32'd7, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'h11BB3344) begin
            n_err++; $display("FAIL lane_sel0000: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_stall_back_to_back();
        int acc = 0, acks_win = 0, acks_tot = 0, lat;
        logic will_acc, ack_now, stall_now;
        logic [31:0] rd, exp;
        cur = 2'd0;
        for (int k = 0; k < 10; k++) begin
            stb = 1'b1; we = 1'b1; sel = 4'hF;
            addr = (k % 2 == 1) ? 32'd2 : 32'd1;
            wdata = 32'hA000_0000 | 32'(k);
            will_acc = !stall[0];
            ack_now = ack[0];
            stall_now = stall[0];
            if (ack_now) begin
                n_cmp++;
                if (stall_now !== 1'b0) begin
                    n_err++; $display("FAIL ack_cycle_stall k=%0d: stall=%b required 0", k, stall_now);
                end
            end
            @(posedge clk); #1;
            if (will_acc) begin
                acc++;
                model_write(cur, addr, wdata, sel);
            end
            if (ack[0]) acks_win++;
            if (ack_now) begin
                n_cmp++;
                if (ack[0] !== 1'b0 || stall[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_accept k=%0d: ack=%b stall=%b required 0/1", k, ack[0], stall[0]);
                end
            end
        end
        stb = 1'b0;
        acks_tot = acks_win;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack[0]) acks_tot++;
        end
        n_cmp++;
        if (acks_win !== 3) begin n_err++; $display("FAIL stall_window_acks: got %0d required 3", acks_win); end
        n_cmp++;
        if (acc !== 4 || acks_tot !== acc) begin
            n_err++; $display("FAIL stall_ack_per_accept: acks %0d accepts %0d required 4/4", acks_tot, acc);
        end
        do_req(1'b0, 32'd1, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'hA000_0006) begin
            n_err++; $display("FAIL stall_data_a1: got %h required %h", rd, exp);
        end
        do_req(1'b0, 32'd2, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'hA000_0009) begin
            n_err++; $display("FAIL stall_data_a2: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd, exp;
        cur = 2'd0;
        do_req(1'b1, 32'd0, 32'hCAFEF00D, 4'hF, lat, rd);
        do_req(1'b1, 32'd1024, 32'h12345678, 4'hF, lat, rd);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL oor_write_lat: got %0d required 2", lat); end
        do_req(1'b0, 32'd1024, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'hFFFF_FFFF || lat !== 2) begin
            n_err++; $display("FAIL oor_read: got %h lat %0d required %h lat 2", rd, lat, exp);
        end
        do_req(1'b0, 32'd0, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL oor_no_wrap: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, nack = 0; logic [31:0] rd, exp;
        cur = 2'd1;
        do_req(1'b1, 32'd3, 32'h0, 4'hF, lat, rd);
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL ws3_write_lat: got %0d required 4", lat); end
        stb = 1'b1; we = 1'b1; addr = 32'd3; wdata = 32'h55555555; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        n_cmp++;
        if (stall[1] !== 1'b1) begin n_err++; $display("FAIL rst_mid_accept: stall=%b required 1", stall[1]); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (stall[1] !== 1'b0 || ack[1] !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_state: stall=%b ack=%b required 0/0", stall[1], ack[1]);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack[1]) nack++;
        end
        n_cmp++;
        if (nack !== 0) begin n_err++; $display("FAIL rst_mid_no_ack: got %0d acks required 0", nack); end
        do_req(1'b0, 32'd3, 32'h0, 4'hF, lat, rd);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if (rd !== exp || rd !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_uncommitted: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_latency_sweep();
        int lat, want; logic [31:0] rd, exp, last;
        for (int p = 0; p < 2; p++) begin
            cur  = (p == 0) ? 2'd2 : 2'd3;
            want = (p == 0) ? 1 : 5;
            do_req(1'b1, 32'd1, 32'h0101_0101 << p, 4'hF, lat, rd);
            n_cmp++;
            if (lat !== want) begin n_err++; $display("FAIL sweep_wlat dut%0d: got %0d required %0d", cur, lat, want); end
            do_req(1'b0, 32'd1, 32'h0, 4'hF, lat, rd);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (lat !== want || rd !== exp) begin
                n_err++;
                $display("FAIL sweep_read dut%0d: got %h lat %0d required %h lat %0d", cur, rd, lat, exp, want);
            end
            last = exp;
            do_req(1'b1, 32'd1, 32'h0F0F_0F0F, 4'hF, lat, rd);
            n_cmp++;
            if (rd !== last) begin
                n_err++; $display("FAIL sweep_hold dut%0d: data %h required %h", cur, rd, last);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0; cur = 2'd0;
        @(posedge clk); #1;
        test_reset();
        test_full_word();
        test_byte_lane();
        test_stall_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_latency_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
